// File: rtl/data_out_serializer.sv
// Word-to-byte serializer. A 32-bit word is captured on Load and sent out
// as 1, 2 or 4 bytes over a valid/ready byte channel. Each byte carries an
// address that starts at the captured base and counts up, wrapping at the
// address width. All outputs are registered.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for Load; ByteValid=0, Busy=0; Done may pulse here
//  SEND  | presenting byte 'index' of the captured word until accepted
module data_out_serializer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [31:0]           I,
    input  logic                  Load,
    input  logic [1:0]            Size,
    input  logic                  Order,
    input  logic [ADDR_WIDTH-1:0] AddrBase,
    output logic [7:0]            ByteOut,
    output logic                  ByteValid,
    input  logic                  ByteReady,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [31:0]           word, word_nxt;
    logic [1:0]            last_idx, last_idx_nxt;   // byte count minus one
    logic                  order_q, order_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [1:0]            index, index_nxt;

    logic [7:0]            byte_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  valid_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;

    // Byte k of the selected field; big-endian order counts down from the
    // top byte of the field, not from the top of the 32-bit word.
    function automatic logic [7:0] pick_byte(
        input logic [31:0] w,
        input logic [1:0]  last,
        input logic        ord,
        input logic [1:0]  k
    );
        logic [1:0] pos;
        pos = ord ? (last - k) : k;
        return w[{pos, 3'b000} +: 8];
    endfunction

    // State, captured transfer context and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            word      <= '0;
            last_idx  <= '0;
            order_q   <= 1'b0;
            base      <= '0;
            index     <= '0;
            ByteOut   <= '0;
            Address   <= '0;
            ByteValid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            word      <= word_nxt;
            last_idx  <= last_idx_nxt;
            order_q   <= order_nxt;
            base      <= base_nxt;
            index     <= index_nxt;
            ByteOut   <= byte_nxt;
            Address   <= addr_nxt;
            ByteValid <= valid_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the first byte is presented on the edge that samples Load.
    always_comb begin
        state_nxt    = state;
        word_nxt     = word;
        last_idx_nxt = last_idx;
        order_nxt    = order_q;
        base_nxt     = base;
        index_nxt    = index;
        byte_nxt     = ByteOut;
        addr_nxt     = Address;
        valid_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (Load) begin
                    state_nxt = SEND;
                    word_nxt  = I;
                    case (Size)
                        2'b00:   last_idx_nxt = 2'd0;
                        2'b01:   last_idx_nxt = 2'd1;
                        default: last_idx_nxt = 2'd3;
                    endcase
                    order_nxt = Order;
                    base_nxt  = AddrBase;
                    index_nxt = 2'd0;
                    byte_nxt  = pick_byte(I, last_idx_nxt, Order, 2'd0);
                    addr_nxt  = AddrBase;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            SEND: begin
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
                if (ByteReady) begin
                    if (index == last_idx) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        index_nxt = index + 2'd1;
                        byte_nxt  = pick_byte(word, last_idx, order_q, index_nxt);
                        addr_nxt  = base + ADDR_WIDTH'(index_nxt);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
